idma_desc64_submit_arb: RTL and testbench
=========================================

IDMA_DESC64_SUBMIT_ARB -- requirements
Module: idma_desc64_submit_arb

Interface
REQ-001 SHALL have parameter NumReq, default 4, number of descriptor submitters (2..16).
REQ-002 SHALL have parameter AddrWidth, default 64, descriptor address width.
REQ-003 SHALL have parameter MaxOutst, default 8, outstanding descriptors allowed per submitter (power of 2).
REQ-004 SHALL have parameter IdDepth, default 16, completion-tracking FIFO depth (power of 2, at least MaxOutst).
REQ-005 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req_addr_i  input  NumReq x AddrWidth  descriptor address per submitter.
REQ-008 SHALL have port req_valid_i  input  NumReq  submission valid per submitter.
REQ-009 SHALL have port req_ready_o  output  NumReq  submission accepted per submitter.
REQ-010 SHALL have port desc_addr_o  output  AddrWidth  address toward descriptor-address queue.
REQ-011 SHALL have port desc_valid_o  output  1  queue write valid.
REQ-012 SHALL have port desc_ready_i  input  1  queue write ready.
REQ-013 SHALL have port desc_done_i  input  1  one-cycle pulse per completed descriptor, in submission order.
REQ-014 SHALL have port irq_o  output  NumReq  one-cycle completion pulse to the owning submitter.
REQ-015 SHALL have port outst_o  output  NumReq x $clog2(MaxOutst+1)  outstanding count per submitter.
REQ-016 SHALL have port busy_o  output  1  any descriptor buffered or outstanding.
REQ-017 SHALL have port err_o  output  1  sticky: desc_done_i received with tracking FIFO empty.

Function
REQ-018 SHALL grant at most one submitter per cycle, round-robin, pointer advancing past the winner only on an accepted grant.
REQ-019 SHALL consider submitter i eligible only if req_valid_i[i], outst[i] < MaxOutst, tracking FIFO not full, and output buffer empty or draining this cycle.
REQ-020 SHALL assert req_ready_o[i] combinationally only for the granted submitter; no ready depends on another submitter's ready.
REQ-021 SHALL latch the granted address into a one-entry output buffer; desc_valid_o rises the cycle after grant (latency 1).
REQ-022 SHALL hold desc_addr_o stable while desc_valid_o && !desc_ready_i; valid never drops without handshake.
REQ-023 SHALL accept a new grant in the same cycle the buffer drains (desc_valid_o && desc_ready_i), giving full throughput.
REQ-024 SHALL push the winner index into the tracking FIFO and increment outst[winner] on grant.
REQ-025 SHALL on desc_done_i pop the FIFO head h, decrement outst[h], and pulse irq_o[h] the next cycle.
REQ-026 SHALL leave outst[i] unchanged when grant and completion hit submitter i in the same cycle.
REQ-027 SHALL allow FIFO push and pop in the same cycle, including when full (pop frees the slot, push permitted).
REQ-028 SHALL ignore desc_done_i with FIFO empty apart from setting err_o; no counter underflow.
REQ-029 SHALL drive busy_o = desc_valid_o or FIFO non-empty.

Reset
REQ-030 SHALL on rst_i clear buffer, FIFO, counters, RR pointer (to submitter 0), err_o; desc_valid_o, req_ready_o, irq_o, busy_o, outst_o read 0.
REQ-031 SHALL abandon in-flight entries on reset mid-operation; completions for them after reset set err_o.

Structure
REQ-032 SHALL place the idma_desc64_submit_arb_pkg typedefs (req index, counter type) and the function computing counter width in a shared package.
REQ-033 SHALL implement the tracking queue as one sub-module, idma_desc64_submit_idfifo (push/pop/full/empty/head).

Verification
REQ-034 SHALL cover: all 4 valid, desc_ready_i=1 -> grants 0,1,2,3,0 on consecutive cycles, one desc per cycle.
REQ-035 SHALL cover: desc_ready_i=0 for 5 cycles with addr 0x1000 -> desc_addr_o stays 0x1000, no further req_ready_o.
REQ-036 SHALL cover: submitter 2 submits 8 with no done -> ninth blocked, others still granted; one done -> submitter 2 accepted again.
REQ-037 SHALL cover: submissions 1,3,1 then three done pulses -> irq_o[1], irq_o[3], irq_o[1] in order, outst returns to 0.
REQ-038 SHALL cover: done on empty FIFO -> err_o=1 and stays until rst_i; counters unchanged.
REQ-039 SHALL cover: rst_i asserted with 3 outstanding -> all outputs 0 within the same cycle, RR restarts at submitter 0.

Source files
------------

// File: rtl/idma_desc64_submit_arb_pkg.sv
// Shared types and helpers for the descriptor submission arbiter.
package idma_desc64_submit_arb_pkg;

  localparam int MaxNumReq = 16;

  typedef logic [$clog2(MaxNumReq)-1:0] req_idx_t;
  // Wide enough for any MaxOutst up to 128; narrowed to the real width at use.
  typedef logic [7:0] cnt_t;

  function automatic int cnt_width(input int max_outst);
    return $clog2(max_outst + 1);
  endfunction

  function automatic cnt_t cnt_next(input cnt_t c, input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return c + cnt_t'(1);
      2'b01:   return c - cnt_t'(1);
      default: return c;
    endcase
  endfunction

endpackage

// File: rtl/idma_desc64_submit_idfifo.sv
// Completion-tracking queue of submitter indices, in submission order.
module idma_desc64_submit_idfifo
  import idma_desc64_submit_arb_pkg::*;
#(
  parameter int Depth = 16
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  req_idx_t data,
  output req_idx_t head,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] FullCnt = (AW+1)'(Depth);

  req_idx_t        mem [Depth];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     cnt_q;
  logic            do_push, do_pop;

  // A pop in the same cycle frees the slot, so pushing while full is legal then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (cnt_q == FullCnt);
  assign empty   = (cnt_q == '0);
  assign head    = mem[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/idma_desc64_submit_arb.sv
// Round-robin descriptor submission arbiter with per-submitter outstanding
// tracking and in-order completion interrupts.
module idma_desc64_submit_arb
  import idma_desc64_submit_arb_pkg::*;
#(
  parameter int NumReq    = 4,
  parameter int AddrWidth = 64,
  parameter int MaxOutst  = 8,
  parameter int IdDepth   = 16,
  localparam int CntW     = cnt_width(MaxOutst)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumReq-1:0][AddrWidth-1:0] req_addr_i,
  input  logic [NumReq-1:0]                req_valid_i,
  output logic [NumReq-1:0]                req_ready_o,
  output logic [AddrWidth-1:0]             desc_addr_o,
  output logic                             desc_valid_o,
  input  logic                             desc_ready_i,
  input  logic                             desc_done_i,
  output logic [NumReq-1:0]                irq_o,
  output logic [NumReq-1:0][CntW-1:0]      outst_o,
  output logic                             busy_o,
  output logic                             err_o
);

  logic [NumReq-1:0][CntW-1:0] cnt_q;
  logic [NumReq-1:0]           elig;
  logic [2*NumReq-1:0]         dbl;
  logic [NumReq-1:0]           rot;
  req_idx_t                    rr_q, win, head;
  logic                        grant, pop, buf_free, slot_ok;
  logic                        fifo_full, fifo_empty;
  logic [AddrWidth-1:0]        win_addr;
  int                          off, wsum;

  assign pop      = desc_done_i && !fifo_empty;
  assign buf_free = !desc_valid_o || desc_ready_i;
  assign slot_ok  = !fifo_full || pop;

  always_comb begin
    for (int i = 0; i < NumReq; i++)
      elig[i] = req_valid_i[i] && (cnt_q[i] != CntW'(MaxOutst)) && buf_free && slot_ok && !rst_i;
  end

  // Rotate eligibility so the RR pointer sits at bit 0, then take the first set bit.
  always_comb begin
    dbl   = {elig, elig} >> rr_q;
    rot   = dbl[NumReq-1:0];
    grant = 1'b0;
    off   = 0;
    for (int j = 0; j < NumReq; j++) begin
      if (!grant && rot[j]) begin
        grant = 1'b1;
        off   = j;
      end
    end
    wsum = int'(rr_q) + off;
    if (wsum >= NumReq) wsum = wsum - NumReq;
    win = req_idx_t'(wsum);
  end

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NumReq; i++) begin
      req_ready_o[i] = grant && (win == req_idx_t'(i));
      if (req_ready_o[i]) win_addr = req_addr_i[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q         <= '0;
      desc_valid_o <= 1'b0;
      desc_addr_o  <= '0;
      cnt_q        <= '0;
      irq_o        <= '0;
      err_o        <= 1'b0;
    end else begin
      if (grant) begin
        rr_q         <= (win == req_idx_t'(NumReq-1)) ? '0 : win + 1'b1;
        desc_valid_o <= 1'b1;
        desc_addr_o  <= win_addr;
      end else if (desc_ready_i) begin
        desc_valid_o <= 1'b0;
      end
      // Grant and completion on the same submitter cancel out in cnt_next.
      for (int i = 0; i < NumReq; i++) begin
        cnt_q[i] <= CntW'(cnt_next(cnt_t'(cnt_q[i]), req_ready_o[i],
                                   pop && (head == req_idx_t'(i))));
        irq_o[i] <= pop && (head == req_idx_t'(i));
      end
      if (desc_done_i && fifo_empty) err_o <= 1'b1;
    end
  end

  idma_desc64_submit_idfifo #(
    .Depth (IdDepth)
  ) u_idfifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (grant),
    .pop   (pop),
    .data  (win),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign outst_o = cnt_q;
  assign busy_o  = desc_valid_o || !fifo_empty;

endmodule

// File: tb/tb_idma_desc64_submit_arb.sv
// Scenario bench for idma_desc64_submit_arb against a queue-based reference model.
module tb_idma_desc64_submit_arb;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int MO = 8;
  localparam int ID = 16;
  localparam int CW = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N-1:0][AW-1:0]   req_addr = '0;
  logic [N-1:0]           req_valid = '0;
  logic [N-1:0]           req_ready;
  logic [AW-1:0]          desc_addr;
  logic                   desc_valid;
  logic                   desc_ready = 1'b0;
  logic                   desc_done = 1'b0;
  logic [N-1:0]           irq;
  logic [N-1:0][CW-1:0]   outst;
  logic                   busy, err;

  always #5 clk = ~clk;

  idma_desc64_submit_arb #(
    .NumReq(N), .AddrWidth(AW), .MaxOutst(MO), .IdDepth(ID)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_addr_i(req_addr), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .desc_addr_o(desc_addr), .desc_valid_o(desc_valid), .desc_ready_i(desc_ready),
    .desc_done_i(desc_done), .irq_o(irq), .outst_o(outst),
    .busy_o(busy), .err_o(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: submission-order queue of owners plus plain counters.
  int            q[$];
  int            m_outst[N];
  int            m_rr;
  bit            m_bv;
  logic [AW-1:0] m_ba;
  logic [N-1:0]  m_irq;
  bit            m_err;
  bit            hold_addr = 1'b0;

  task automatic m_reset();
    q.delete();
    for (int i = 0; i < N; i++) m_outst[i] = 0;
    m_rr = 0; m_bv = 0; m_ba = '0; m_irq = '0; m_err = 0;
  endtask

  // One clock: drive at negedge, compare just after, then advance the model
  // to what the following rising edge should produce.
  task automatic step(input logic [N-1:0] v, input logic rdy, input logic dn, input logic r);
    logic [N-1:0]         exp_rdy;
    logic [N-1:0][CW-1:0] exp_out;
    int w, h, idx;
    @(negedge clk);
    rst = r; req_valid = v; desc_ready = rdy; desc_done = dn;
    if (!hold_addr)
      for (int i = 0; i < N; i++) req_addr[i] = {$urandom, $urandom};
    if (r) m_reset();
    exp_rdy = '0;
    w = -1;
    if (!r && (!m_bv || rdy) && (q.size() < ID || (dn && q.size() > 0))) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (w < 0 && v[idx] && m_outst[idx] < MO) w = idx;
      end
    end
    if (w >= 0) exp_rdy[w] = 1'b1;
    for (int i = 0; i < N; i++) exp_out[i] = CW'(m_outst[i]);
    #1;
    n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL ready t=%0t got %b want %b", $time, req_ready, exp_rdy); end
    n_cmp++; if (desc_valid !== m_bv) begin n_bad++; $display("FAIL desc_valid t=%0t got %b want %b", $time, desc_valid, m_bv); end
    if (m_bv) begin
      n_cmp++; if (desc_addr !== m_ba) begin n_bad++; $display("FAIL desc_addr t=%0t got %h want %h", $time, desc_addr, m_ba); end
    end
    n_cmp++; if (irq !== m_irq) begin n_bad++; $display("FAIL irq t=%0t got %b want %b", $time, irq, m_irq); end
    n_cmp++; if (outst !== exp_out) begin n_bad++; $display("FAIL outst t=%0t got %h want %h", $time, outst, exp_out); end
    n_cmp++; if (busy !== (m_bv || q.size() > 0)) begin n_bad++; $display("FAIL busy t=%0t got %b want %b", $time, busy, (m_bv || q.size() > 0)); end
    n_cmp++; if (err !== m_err) begin n_bad++; $display("FAIL err t=%0t got %b want %b", $time, err, m_err); end
    if (r) return;
    if (dn && q.size() == 0) m_err = 1;
    m_irq = '0;
    if (dn && q.size() > 0) begin
      h = q.pop_front();
      m_outst[h]--;
      m_irq[h] = 1'b1;
    end
    if (w >= 0) begin
      q.push_back(w);
      m_outst[w]++;
      m_rr = (w + 1) % N;
      m_bv = 1;
      m_ba = req_addr[w];
    end else if (rdy) begin
      m_bv = 0;
    end
  endtask

  task automatic do_reset();
    step('0, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && q.size() > 0; k++) step('0, 1'b1, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL drain_bound left %0d want 0", q.size()); end
  endtask

  task automatic test_reset();
    step('1, 1'b1, 1'b0, 1'b1);
    n_cmp++; if ({req_ready, desc_valid, irq, busy, err} !== '0 || outst !== '0) begin
      n_bad++; $display("FAIL reset_outputs got rdy=%b v=%b irq=%b busy=%b err=%b outst=%h want all 0", req_ready, desc_valid, irq, busy, err, outst);
    end
    step('0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_round_robin();
    int seq[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] e;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step('1, 1'b1, 1'b0, 1'b0);
      e = N'(1) << seq[k];
      n_cmp++; if (req_ready !== e) begin n_bad++; $display("FAIL rr_grant%0d got %b want %b", k, req_ready, e); end
      if (k > 0) begin
        n_cmp++; if (desc_valid !== 1'b1) begin n_bad++; $display("FAIL rr_stream%0d got %b want 1", k, desc_valid); end
      end
    end
    drain();
    n_cmp++; if (outst !== '0) begin n_bad++; $display("FAIL rr_outst got %h want 0", outst); end
  endtask

  task automatic test_stall();
    do_reset();
    hold_addr = 1'b1;
    req_addr[0] = 64'h1000;
    step(4'b0001, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL stall_first got %b want 0001", req_ready); end
    for (int k = 0; k < 5; k++) begin
      step(4'b0001, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (req_ready !== '0 || desc_valid !== 1'b1 || desc_addr !== 64'h1000) begin
        n_bad++; $display("FAIL stall_hold%0d got rdy=%b v=%b addr=%h want 0/1/1000", k, req_ready, desc_valid, desc_addr);
      end
    end
    hold_addr = 1'b0;
    drain();
  endtask

  task automatic test_max_outst();
    do_reset();
    for (int k = 0; k < 8; k++) step(4'b0100, 1'b1, 1'b0, 1'b0);
    step(4'b0100, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (req_ready !== '0 || outst[2] !== 4'd8) begin n_bad++; $display("FAIL max_block got rdy=%b outst2=%0d want 0/8", req_ready, outst[2]); end
    step(4'b1101, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL max_others got %b want 1000", req_ready); end
    step('0, 1'b1, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL max_reopen got %b want 0100", req_ready); end
    drain();
  endtask

  task automatic test_irq_order();
    do_reset();
    step(4'b0010, 1'b1, 1'b0, 1'b0);
    step(4'b1000, 1'b1, 1'b0, 1'b0);
    step(4'b0010, 1'b1, 1'b0, 1'b0);
    step('0, 1'b1, 1'b1, 1'b0);
    step('0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (irq !== 4'b0010) begin n_bad++; $display("FAIL irq_first got %b want 0010", irq); end
    step('0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (irq !== 4'b1000) begin n_bad++; $display("FAIL irq_second got %b want 1000", irq); end
    step('0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (irq !== 4'b0010) begin n_bad++; $display("FAIL irq_third got %b want 0010", irq); end
    n_cmp++; if (outst !== '0) begin n_bad++; $display("FAIL irq_outst got %h want 0", outst); end
    step('0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (irq !== '0) begin n_bad++; $display("FAIL irq_oneshot got %b want 0", irq); end
  endtask

  task automatic test_err();
    do_reset();
    step('0, 1'b0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (err !== 1'b1 || outst !== '0) begin n_bad++; $display("FAIL err_set got err=%b outst=%h want 1/0", err, outst); end
    for (int k = 0; k < 3; k++) step(4'b0001, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", err); end
    drain();
    step('0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear got %b want 0", err); end
    step('0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) step(4'b0111, 1'b1, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy got %b want 1", busy); end
    step('1, 1'b1, 1'b0, 1'b1);
    n_cmp++; if ({req_ready, desc_valid, irq, busy, err} !== '0 || outst !== '0) begin
      n_bad++; $display("FAIL mid_reset got rdy=%b v=%b irq=%b busy=%b err=%b outst=%h want all 0", req_ready, desc_valid, irq, busy, err, outst);
    end
    step('1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_rr_restart got %b want 0001", req_ready); end
    step('0, 1'b1, 1'b1, 1'b0);
    step('0, 1'b1, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL mid_stale_done got %b want 1", err); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++)
      step(N'($urandom), ($urandom % 10) < 7, ($urandom % 10) < 3, 1'b0);
    drain();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_max_outst();
    test_irq_order();
    test_err();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
